// File: rtl/uart_mem_scheduler.sv
// Registered arbiter for the shared data-memory write port: the CPU has priority,
// and the two UART RX channels are serviced round-robin. Each received byte is followed by a marker write.
module uart_mem_scheduler #(
  parameter int unsigned ADDR_W               = 11,
  parameter int unsigned BUF_DEPTH            = 16,
  parameter logic [ADDR_W-1:0] RX0_BASE       = 11'h700,
  parameter logic [ADDR_W-1:0] RX1_BASE       = 11'h740,
  parameter logic [ADDR_W-1:0] TX0_ADDR       = 11'h7F0,
  parameter logic [ADDR_W-1:0] TX1_ADDR       = 11'h7F1,
  parameter logic [7:0]        MARK           = 8'h0C,
  localparam int unsigned      PTR_W          = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              cpuRead,
  input  logic              cpuWrite,
  input  logic [7:0]        cpuWriteData,
  input  logic              rxReady0,
  input  logic              rxReady1,
  input  logic [7:0]        rxData0,
  input  logic [7:0]        rxData1,
  input  logic              txBusy0,
  input  logic              txBusy1,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWriteData,
  output logic              memWrite,
  output logic              rxClear0,
  output logic              rxClear1,
  output logic [7:0]        txData,
  output logic              tx0Enable,
  output logic              tx1Enable,
  output logic              cpuStall,
  output logic [PTR_W-1:0]  ptr0,
  output logic [PTR_W-1:0]  ptr1
);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_MARK} state_t;

  state_t            state_q, state_d;
  logic              ch_q, ch_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              rx_clear0_q, rx_clear0_d;
  logic              rx_clear1_q, rx_clear1_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx0_en_q, tx0_en_d;
  logic              tx1_en_q, tx1_en_d;
  logic              cpu_stall_q, cpu_stall_d;
  logic [PTR_W-1:0]  ptr0_q, ptr0_d;
  logic [PTR_W-1:0]  ptr1_q, ptr1_d;

  logic              tx_hit0, tx_hit1, cpu_mem, sel;
  logic [PTR_W-1:0]  next_ptr;

  assign tx_hit0 = cpuWrite && (cpuAddr == TX0_ADDR);
  assign tx_hit1 = cpuWrite && (cpuAddr == TX1_ADDR);
  assign cpu_mem = (cpuWrite || cpuRead) && (cpuAddr != TX0_ADDR) && (cpuAddr != TX1_ADDR);
  // Both ready: the round-robin bit picks; otherwise whichever channel is ready.
  assign sel      = (rxReady0 && rxReady1) ? rr_q : rxReady1;
  assign next_ptr = (ch_q ? ptr1_q : ptr0_q) + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    rr_d        = rr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    rx_clear0_d = 1'b0;
    rx_clear1_d = 1'b0;
    tx_data_d   = tx_data_q;
    tx0_en_d    = 1'b0;
    tx1_en_d    = 1'b0;
    cpu_stall_d = 1'b0;
    ptr0_d      = ptr0_q;
    ptr1_d      = ptr1_q;

    // Transmit launch does not touch the memory port, so it runs in every state.
    if (tx_hit0) begin
      if (txBusy0) begin
        cpu_stall_d = 1'b1;
      end else begin
        tx0_en_d  = 1'b1;
        tx_data_d = cpuWriteData;
      end
    end
    if (tx_hit1) begin
      if (txBusy1) begin
        cpu_stall_d = 1'b1;
      end else begin
        tx1_en_d  = 1'b1;
        tx_data_d = cpuWriteData;
      end
    end

    case (state_q)
      IDLE: begin
        if (cpu_mem) begin
          mem_addr_d  = cpuAddr;
          mem_wdata_d = cpuWriteData;
          mem_write_d = cpuWrite;
        end else if (rxReady0 || rxReady1) begin
          if (rxReady0 && rxReady1) rr_d = ~rr_q;
          ch_d        = sel;
          mem_write_d = 1'b1;
          mem_addr_d  = sel ? (RX1_BASE + ADDR_W'(ptr1_q)) : (RX0_BASE + ADDR_W'(ptr0_q));
          mem_wdata_d = sel ? rxData1 : rxData0;
          rx_clear0_d = ~sel;
          rx_clear1_d = sel;
          state_d     = WR_DATA;
        end
      end
      WR_DATA: begin
        if (ch_q) ptr1_d = next_ptr;
        else      ptr0_d = next_ptr;
        mem_write_d = 1'b1;
        mem_addr_d  = (ch_q ? RX1_BASE : RX0_BASE) + ADDR_W'(next_ptr);
        mem_wdata_d = MARK;
        // The next cycle is still busy with the marker, so hold the CPU off.
        if (cpu_mem) cpu_stall_d = 1'b1;
        state_d = WR_MARK;
      end
      WR_MARK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= 1'b0;
      rr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rx_clear0_q <= 1'b0;
      rx_clear1_q <= 1'b0;
      tx_data_q   <= '0;
      tx0_en_q    <= 1'b0;
      tx1_en_q    <= 1'b0;
      cpu_stall_q <= 1'b0;
      ptr0_q      <= '0;
      ptr1_q      <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      rr_q        <= rr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      rx_clear0_q <= rx_clear0_d;
      rx_clear1_q <= rx_clear1_d;
      tx_data_q   <= tx_data_d;
      tx0_en_q    <= tx0_en_d;
      tx1_en_q    <= tx1_en_d;
      cpu_stall_q <= cpu_stall_d;
      ptr0_q      <= ptr0_d;
      ptr1_q      <= ptr1_d;
    end
  end

  assign memAddr      = mem_addr_q;
  assign memWriteData = mem_wdata_q;
  assign memWrite     = mem_write_q;
  assign rxClear0     = rx_clear0_q;
  assign rxClear1     = rx_clear1_q;
  assign txData       = tx_data_q;
  assign tx0Enable    = tx0_en_q;
  assign tx1Enable    = tx1_en_q;
  assign cpuStall     = cpu_stall_q;
  assign ptr0         = ptr0_q;
  assign ptr1         = ptr1_q;

endmodule

// File: tb/tb_uart_mem_scheduler.sv
// Directed vector bench for uart_mem_scheduler: each record holds one cycle of inputs
// and the registered outputs expected right after that cycle's clock edge.
module tb_uart_mem_scheduler;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  typedef struct {
    logic        rst;
    logic [10:0] addr;
    logic        rd, wr;
    logic [7:0]  wd;
    logic        r0;
    logic [7:0]  d0;
    logic        r1;
    logic [7:0]  d1;
    logic        b0, b1;
    logic        mw;
    logic [10:0] ma;
    logic [7:0]  md;
    logic [1:0]  clr;   // {rxClear1, rxClear0}
    logic [1:0]  ten;   // {tx1Enable, tx0Enable}
    logic [7:0]  td;
    logic        st;
    logic [3:0]  p0, p1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cpuAddr;
  logic        cpuRead, cpuWrite;
  logic [7:0]  cpuWriteData;
  logic        rxReady0, rxReady1;
  logic [7:0]  rxData0, rxData1;
  logic        txBusy0, txBusy1;
  logic [10:0] memAddr;
  logic [7:0]  memWriteData;
  logic        memWrite, rxClear0, rxClear1;
  logic [7:0]  txData;
  logic        tx0Enable, tx1Enable, cpuStall;
  logic [3:0]  ptr0, ptr1;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_mem_scheduler dut (
    .clk(clk), .reset(reset),
    .cpuAddr(cpuAddr), .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuWriteData(cpuWriteData),
    .rxReady0(rxReady0), .rxReady1(rxReady1), .rxData0(rxData0), .rxData1(rxData1),
    .txBusy0(txBusy0), .txBusy1(txBusy1),
    .memAddr(memAddr), .memWriteData(memWriteData), .memWrite(memWrite),
    .rxClear0(rxClear0), .rxClear1(rxClear1), .txData(txData),
    .tx0Enable(tx0Enable), .tx1Enable(tx1Enable), .cpuStall(cpuStall),
    .ptr0(ptr0), .ptr1(ptr1)
  );

  task automatic chk(input string tag, input int idx, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, nm, act, exp);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd0,4'd0};
    return v;
  endfunction

  // full=1 also checks memAddr/memWriteData/txData when no write or pulse is expected.
  task automatic run(input vec_t v, input bit full, input string tag, input int idx);
    reset = v.rst; cpuAddr = v.addr; cpuRead = v.rd; cpuWrite = v.wr; cpuWriteData = v.wd;
    rxReady0 = v.r0; rxData0 = v.d0; rxReady1 = v.r1; rxData1 = v.d1;
    txBusy0 = v.b0; txBusy1 = v.b1;
    @(posedge clk);
    #1;
    chk(tag, idx, "memWrite", {31'd0, memWrite}, {31'd0, v.mw});
    if (v.mw || full) begin
      chk(tag, idx, "memAddr", {21'd0, memAddr}, {21'd0, v.ma});
      chk(tag, idx, "memWriteData", {24'd0, memWriteData}, {24'd0, v.md});
    end
    chk(tag, idx, "rxClear", {30'd0, rxClear1, rxClear0}, {30'd0, v.clr});
    chk(tag, idx, "txEnable", {30'd0, tx1Enable, tx0Enable}, {30'd0, v.ten});
    if ((v.ten != 2'b00) || full)
      chk(tag, idx, "txData", {24'd0, txData}, {24'd0, v.td});
    chk(tag, idx, "cpuStall", {31'd0, cpuStall}, {31'd0, v.st});
    chk(tag, idx, "ptr0", {28'd0, ptr0}, {28'd0, v.p0});
    chk(tag, idx, "ptr1", {28'd0, ptr1}, {28'd0, v.p1});
    $display("%s[%0d] mw=%0b addr=%h data=%h clr=%b%b ten=%b%b td=%h stall=%0b p0=%0d p1=%0d",
             tag, idx, memWrite, memAddr, memWriteData, rxClear1, rxClear0,
             tx1Enable, tx0Enable, txData, cpuStall, ptr0, ptr1);
  endtask

  initial begin
    vec_t v;
    logic [3:0] p;

    // Reset and five quiet cycles: everything zero.
    v = idle_vec(); v.rst = I;
    run(v, 1'b1, "reset", 0);
    run(v, 1'b1, "reset", 1);
    v.rst = O;
    for (int i = 0; i < 5; i++) run(v, 1'b1, "idle", i);

    //                 rst addr      rd wr wd       r0 d0      r1 d1      b0 b1   mw ma        md      clr   ten   td      st p0   p1
    // single UART0 byte
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'h41,O,8'h00,O,O, I,11'h700,8'h41,2'b01,2'b00,8'h00,O,4'd0,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'h41,O,8'h00,O,O, I,11'h701,8'h0C,2'b00,2'b00,8'h00,O,4'd1,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd1,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd1,4'd0});
    // both ready with rr=0: UART0 first, UART1 three cycles later
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hA0,I,8'hB0,O,O, I,11'h701,8'hA0,2'b01,2'b00,8'h00,O,4'd1,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hA0,I,8'hB0,O,O, I,11'h702,8'h0C,2'b00,2'b00,8'h00,O,4'd2,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,I,8'hB0,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd2,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,I,8'hB0,O,O, I,11'h740,8'hB0,2'b10,2'b00,8'h00,O,4'd2,4'd0});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,I,8'hB0,O,O, I,11'h741,8'h0C,2'b00,2'b00,8'h00,O,4'd2,4'd1});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd2,4'd1});
    // both ready with rr=1: UART1 goes first this time
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hC0,I,8'hC1,O,O, I,11'h741,8'hC1,2'b10,2'b00,8'h00,O,4'd2,4'd1});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hC0,I,8'hC1,O,O, I,11'h742,8'h0C,2'b00,2'b00,8'h00,O,4'd2,4'd2});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hC0,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd2,4'd2});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hC0,O,8'h00,O,O, I,11'h702,8'hC0,2'b01,2'b00,8'h00,O,4'd2,4'd2});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hC0,O,8'h00,O,O, I,11'h703,8'h0C,2'b00,2'b00,8'h00,O,4'd3,4'd2});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd3,4'd2});
    // CPU write wins over a simultaneous rxReady1, no stall
    tbl.push_back(vec_t'{O,11'h010,O,I,8'h5A, O,8'h00,I,8'hD1,O,O, I,11'h010,8'h5A,2'b00,2'b00,8'h00,O,4'd3,4'd2});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,I,8'hD1,O,O, I,11'h742,8'hD1,2'b10,2'b00,8'h00,O,4'd3,4'd2});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,I,8'hD1,O,O, I,11'h743,8'h0C,2'b00,2'b00,8'h00,O,4'd3,4'd3});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd3,4'd3});
    // CPU write arriving mid-RX is stalled and served in the IDLE cycle
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, I,8'hE0,O,8'h00,O,O, I,11'h703,8'hE0,2'b01,2'b00,8'h00,O,4'd3,4'd3});
    tbl.push_back(vec_t'{O,11'h020,O,I,8'h77, I,8'hE0,O,8'h00,O,O, I,11'h704,8'h0C,2'b00,2'b00,8'h00,I,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h020,O,I,8'h77, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h020,O,I,8'h77, O,8'h00,O,8'h00,O,O, I,11'h020,8'h77,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    // reads: TX address has no effect, normal address never writes
    tbl.push_back(vec_t'{O,11'h7F0,I,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h030,I,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    // TX1 immediate launch
    tbl.push_back(vec_t'{O,11'h7F1,O,I,8'h99, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b10,8'h99,O,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    // TX0 busy for three cycles: stall three cycles, then one pulse
    tbl.push_back(vec_t'{O,11'h7F0,O,I,8'h55, O,8'h00,O,8'h00,I,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,I,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h7F0,O,I,8'h55, O,8'h00,O,8'h00,I,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,I,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h7F0,O,I,8'h55, O,8'h00,O,8'h00,I,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,I,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h7F0,O,I,8'h55, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b01,8'h55,O,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,I,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});
    // TX1 request is not held off by the other channel's busy
    tbl.push_back(vec_t'{O,11'h7F1,O,I,8'hAB, O,8'h00,O,8'h00,I,O, O,11'h000,8'h00,2'b00,2'b10,8'hAB,O,4'd4,4'd3});
    tbl.push_back(vec_t'{O,11'h000,O,O,8'h00, O,8'h00,O,8'h00,O,O, O,11'h000,8'h00,2'b00,2'b00,8'h00,O,4'd4,4'd3});

    foreach (tbl[i]) run(tbl[i], 1'b0, "vec", i);

    // Reset while a byte is pending: no clear, pointers back to 0, byte rewritten at base.
    v = idle_vec(); v.rst = I; v.r0 = I; v.d0 = 8'hF0;
    run(v, 1'b1, "rstmid", 0);
    v.rst = O; v.mw = I; v.ma = 11'h700; v.md = 8'hF0; v.clr = 2'b01;
    run(v, 1'b0, "rstmid", 1);
    v = idle_vec(); v.rst = I; v.r0 = I; v.d0 = 8'hF0;
    run(v, 1'b1, "rstmid", 2);
    v = idle_vec();
    run(v, 1'b1, "rstmid", 3);

    // 17 UART1 bytes from ptr1=0: the last one wraps back to 11'h740.
    p = 4'd0;
    for (int b = 0; b < 17; b++) begin
      v = idle_vec(); v.r1 = I; v.d1 = 8'(b);
      v.mw = I; v.ma = 11'h740 + 11'(p); v.md = 8'(b); v.clr = 2'b10; v.p1 = p;
      run(v, 1'b0, "wrap", 3 * b);
      v.clr = 2'b00; v.ma = 11'h740 + 11'(4'(p + 4'd1)); v.md = 8'h0C; v.p1 = 4'(p + 4'd1);
      run(v, 1'b0, "wrap", 3 * b + 1);
      p = 4'(p + 4'd1);
      v = idle_vec(); v.p1 = p;
      run(v, 1'b0, "wrap", 3 * b + 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
